// File: rtl/alu_ctrl_decoder_if.sv
// alu_ctrl_decoder_if: instruction-in / decoded-bundle-out handshake bundle (ALU_CTRL_STATS_EN adds the illegal counter)
interface alu_ctrl_decoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_op_type_1;
    logic [1:0]  out_op_type_2;
    logic        out_op_type_3;
    logic        out_is_signed;
    logic [1:0]  out_a_sel;
    logic [1:0]  out_b_sel;
    logic [31:0] out_imm;
    logic        out_illegal;
`ifdef ALU_CTRL_STATS_EN
    logic [15:0] out_illegal_cnt;
`endif
    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_op_type_1, out_op_type_2, out_op_type_3,
        input  out_is_signed, out_a_sel, out_b_sel, out_imm, out_illegal
`ifdef ALU_CTRL_STATS_EN
        , input out_illegal_cnt
`endif
    );
    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_op_type_1, out_op_type_2, out_op_type_3,
        output out_is_signed, out_a_sel, out_b_sel, out_imm, out_illegal
`ifdef ALU_CTRL_STATS_EN
        , output out_illegal_cnt
`endif
    );
endinterface

// File: rtl/alu_ctrl_decoder.sv
// alu_ctrl_decoder: registered MIPS-to-ALU-control decode stage with 1-entry skid buffer (ALU_CTRL_STATS_EN adds illegal counter)
module alu_ctrl_decoder #(
    parameter int SKID_EN_DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    alu_ctrl_decoder_if.slave bus
);
    typedef struct packed {
        logic        illegal;
        logic [1:0]  op1;
        logic [1:0]  op2;
        logic        op3;
        logic        sgn;
        logic [1:0]  a_sel;
        logic [1:0]  b_sel;
        logic [31:0] imm;
    } bundle_t;

    if (SKID_EN_DEPTH != 1) begin : g_bad_depth
        $error("alu_ctrl_decoder: only SKID_EN_DEPTH=1 is supported");
    end

    function automatic bundle_t mk(input logic [1:0] o1, input logic [1:0] o2, input logic o3,
                                   input logic s, input logic [1:0] a, input logic [1:0] b,
                                   input logic [31:0] imm);
        mk = {1'b0, o1, o2, o3, s, a, b, imm};
    endfunction

    bundle_t     dec, out_q, out_d, skid_q, skid_d;
    logic        out_valid_q, out_valid_d, skid_valid_q, skid_valid_d, in_ready_q, in_ready_d;
    logic        acc, drn;
    logic [5:0]  opc, fn;
    logic [31:0] sext, zext;

    assign opc  = bus.in_instr[31:26];
    assign fn   = bus.in_instr[5:0];
    assign sext = {{16{bus.in_instr[15]}}, bus.in_instr[15:0]};
    assign zext = {16'h0, bus.in_instr[15:0]};

    // Decode the offered instruction; anything unlisted is flagged illegal with all other fields zero.
    always_comb begin
        dec = '0;
        dec.illegal = 1'b1;
        case (opc)
            6'b000000: case (fn)
                6'b000000: dec = mk(2'd0, 2'd0, 1'b0, 1'b0, 2'd1, 2'd2, 32'h0);
                6'b000010: dec = mk(2'd0, {1'b0, bus.in_instr[21]}, 1'b1, 1'b0, 2'd1, 2'd2, 32'h0);
                6'b000011: dec = mk(2'd0, 2'd2, 1'b1, 1'b1, 2'd1, 2'd2, 32'h0);
                6'b000100: dec = mk(2'd0, 2'd0, 1'b0, 1'b0, 2'd1, 2'd3, 32'h0);
                6'b000110: dec = mk(2'd0, 2'd0, 1'b1, 1'b0, 2'd1, 2'd3, 32'h0);
                6'b000111: dec = mk(2'd0, 2'd2, 1'b1, 1'b1, 2'd1, 2'd3, 32'h0);
                6'b100000: dec = mk(2'd2, 2'd0, 1'b0, 1'b1, 2'd0, 2'd0, 32'h0);
                6'b100001: dec = mk(2'd2, 2'd0, 1'b0, 1'b0, 2'd0, 2'd0, 32'h0);
                6'b100010: dec = mk(2'd2, 2'd1, 1'b0, 1'b1, 2'd0, 2'd0, 32'h0);
                6'b100011: dec = mk(2'd2, 2'd1, 1'b0, 1'b0, 2'd0, 2'd0, 32'h0);
                6'b100100: dec = mk(2'd3, 2'd0, 1'b0, 1'b0, 2'd0, 2'd0, 32'h0);
                6'b100101: dec = mk(2'd3, 2'd1, 1'b0, 1'b0, 2'd0, 2'd0, 32'h0);
                6'b100111: dec = mk(2'd3, 2'd2, 1'b0, 1'b0, 2'd0, 2'd0, 32'h0);
                6'b100110: dec = mk(2'd3, 2'd3, 1'b0, 1'b0, 2'd0, 2'd0, 32'h0);
                6'b101010: dec = mk(2'd1, 2'd0, 1'b0, 1'b1, 2'd0, 2'd0, 32'h0);
                6'b101011: dec = mk(2'd1, 2'd0, 1'b0, 1'b0, 2'd0, 2'd0, 32'h0);
                default:   dec = dec;
            endcase
            6'b001000: dec = mk(2'd2, 2'd0, 1'b0, 1'b1, 2'd0, 2'd1, sext);
            6'b001001: dec = mk(2'd2, 2'd0, 1'b0, 1'b0, 2'd0, 2'd1, sext);
            6'b001010: dec = mk(2'd1, 2'd0, 1'b0, 1'b1, 2'd0, 2'd1, sext);
            6'b001011: dec = mk(2'd1, 2'd0, 1'b0, 1'b0, 2'd0, 2'd1, sext);
            6'b001100: dec = mk(2'd3, 2'd0, 1'b0, 1'b0, 2'd0, 2'd1, zext);
            6'b001101: dec = mk(2'd3, 2'd1, 1'b0, 1'b0, 2'd0, 2'd1, zext);
            6'b001110: dec = mk(2'd3, 2'd3, 1'b0, 1'b0, 2'd0, 2'd1, zext);
            6'b001111: dec = mk(2'd3, 2'd1, 1'b0, 1'b0, 2'd2, 2'd1, {bus.in_instr[15:0], 16'h0});
            default:   dec = dec;
        endcase
    end

    // Output register refills from skid first, else from the new decode; a stalled output diverts the accept into skid.
    // in_ready is registered as "skid will be empty", so a full skid can never see a second accept.
    always_comb begin
        acc          = bus.in_valid & in_ready_q;
        drn          = out_valid_q & bus.out_ready;
        out_valid_d  = out_valid_q;
        out_d        = out_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        if (!out_valid_q || drn) begin
            out_valid_d  = skid_valid_q | acc;
            out_d        = skid_valid_q ? skid_q : acc ? dec : out_q;
            skid_valid_d = 1'b0;
        end else if (acc) begin
            skid_valid_d = 1'b1;
            skid_d       = dec;
        end
        in_ready_d = !skid_valid_d;
    end

    // Pipeline state; reset discards both entries and holds in_ready low until the first edge after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_q        <= '0;
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
            in_ready_q   <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_q        <= out_d;
            skid_valid_q <= skid_valid_d;
            skid_q       <= skid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign bus.in_ready      = in_ready_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_op_type_1 = out_q.op1;
    assign bus.out_op_type_2 = out_q.op2;
    assign bus.out_op_type_3 = out_q.op3;
    assign bus.out_is_signed = out_q.sgn;
    assign bus.out_a_sel     = out_q.a_sel;
    assign bus.out_b_sel     = out_q.b_sel;
    assign bus.out_imm       = out_q.imm;
    assign bus.out_illegal   = out_q.illegal;

`ifdef ALU_CTRL_STATS_EN
    logic [15:0] illegal_cnt_q, illegal_cnt_d;

    // Saturating count of illegal bundles actually consumed downstream.
    always_comb begin
        illegal_cnt_d = (drn && out_q.illegal && illegal_cnt_q != 16'hFFFF) ? illegal_cnt_q + 16'd1 : illegal_cnt_q;
    end

    // Counter register, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) illegal_cnt_q <= '0;
        else     illegal_cnt_q <= illegal_cnt_d;
    end

    assign bus.out_illegal_cnt = illegal_cnt_q;
`endif
endmodule

// File: doc/alu_ctrl_decoder.md
Name: alu_ctrl_decoder

Overview:
Decodes a 32-bit MIPS instruction into the selector fields consumed by the combinational ALU: op_type_1/2/3, is_signed, operand-source selects and extended immediate. Sits between instruction fetch and the ALU/operand mux as one registered pipeline stage. Uses valid/ready handshakes on both sides. A 1-entry skid buffer gives full throughput with a registered in_ready.

Parameters:
SKID_EN_DEPTH, 1, skid-buffer entries; only 1 is supported, and other values are a synthesis error.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  instruction offered
- in_ready  out  1  decoder can accept; registered
- in_instr  in  32  MIPS instruction word
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  downstream accepts
- out_op_type_1  out  2  00 shift, 01 SLT, 10 arith, 11 logic
- out_op_type_2  out  2  sub-op, encoded exactly as the ALU expects
- out_op_type_3  out  1  shift direction: 0 left, 1 right
- out_is_signed  out  1  signed compare / overflow check
- out_a_sel  out  2  ALU in_1 source: 00 rs, 01 rt, 10 zero
- out_b_sel  out  2  ALU in_2 source: 00 rt, 01 out_imm, 10 shamt (instr[10:6], zero-extended), 11 rs
- out_imm  out  32  extended immediate
- out_illegal  out  1  opcode/funct not supported

Behaviour:
- Reset (async, immediate):
  - out_valid=0, in_ready=0, skid empty, all output fields 0.
  - in_ready rises on the first clk edge after rst deasserts.
- Latency: an instruction accepted (in_valid&in_ready) at edge N is presented with out_valid=1 after edge N; 1 cycle.
- Output register holds its fields stable while out_valid&!out_ready.
- Skid buffer:
  - If the output register is occupied and not draining when an input is accepted, the decoded input goes to the skid entry.
  - in_ready <= 0 at that edge.
  - When the output drains, the skid entry moves to the output register and in_ready <= 1.
  - Order is preserved; no loss or duplication.
- Simultaneous accept and drain with an empty skid: the output register is reloaded with the new decode and out_valid stays 1.
- Full throughput: one instruction per cycle while out_ready=1.
- R-type decode (opcode 000000), listed as funct: op1,op2,op3,signed,a_sel,b_sel:
  - SLL 000000: 00,00,0,0,rt,shamt
  - SRL 000010 with instr[21]=0: 00,00,1,0,rt,shamt
  - ROTR is SRL with instr[21]=1: 00,01,1,0,rt,shamt
  - SRA 000011: 00,10,1,1,rt,shamt
  - SLLV 000100, SRLV 000110, SRAV 000111: as their fixed counterparts but b_sel=11 (rs)
  - ADD 100000: 10,00,0,1; ADDU 100001: same, signed=0
  - SUB 100010: 10,01,0,1; SUBU 100011: signed=0
  - AND 100100: 11,00; OR 100101: 11,01; NOR 100111: 11,10; XOR 100110: 11,11
  - SLT 101010: 01,00,0,1; SLTU 101011: signed=0
  - All non-shift R-type: a_sel=rs, b_sel=rt.
- I-type decode (all a_sel=rs, b_sel=imm):
  - ADDI 001000: arith add, signed=1, sign-extend
  - ADDIU 001001: signed=0, sign-extend
  - SLTI 001010: signed=1, sign-extend
  - SLTIU 001011: signed=0, sign-extend
  - ANDI 001100, ORI 001101, XORI 001110: logic, zero-extend
  - LUI 001111: logic OR, a_sel=zero, imm={instr[15:0],16'h0}
- Illegal: any other opcode/funct sets out_illegal=1 with all other fields 0. It still passes through the handshake like a normal instruction.
- Undefined a/b/imm fields for legal instructions are driven 0.
- Reset mid-stream: all in-flight entries are discarded; nothing is emitted after reset until a new accept.

Optional Feature:
ALU_CTRL_STATS_EN
- Defined: adds output out_illegal_cnt[15:0], a saturating count of illegal bundles consumed (out_valid&out_ready&out_illegal).
  - Holds at 16'hFFFF once reached.
  - Cleared by rst.
- Undefined: the port and counter are absent; the rest of the behaviour is identical.

Test Plan:
1. Single instruction: rst pulse, then instr 0x012A4020 (ADD $8,$9,$10) with out_ready=1 -> one cycle later out_valid=1, op1=10, op2=00, signed=1, a_sel=00, b_sel=00, illegal=0.
2. Immediate extension: ADDI 0x2128FFFF -> imm=0xFFFFFFFF, b_sel=01. ORI 0x3528FFFF -> imm=0x0000FFFF, op1=11, op2=01. LUI 0x3C081234 -> imm=0x12340000, a_sel=10.
3. Shift decode: SRL 0x00084082 -> op1=00, op2=00, op3=1, b_sel=10. Same word with bit21 set (ROTR) -> op2=01. SRAV 0x01284007 -> op2=10, b_sel=11.
4. Backpressure: stream 4 back-to-back instructions, out_ready=0 for 3 cycles then 1 -> in_ready drops after 2 accepts; all 4 emerge in order, none lost or duplicated.
5. Illegal instruction: opcode 111111 -> out_illegal=1, other fields 0. With ALU_CTRL_STATS_EN, 3 illegal handshakes -> out_illegal_cnt=3. Counter forced to 0xFFFF stays 0xFFFF on a further illegal.
6. Async reset asserted while out_valid=1 and skid full -> out_valid=0 and in_ready=0 immediately without a clock edge. After release, no stale bundle appears.
